seg7_en_ctrl: RTL and testbench
===============================

// Module: seg7_en_ctrl
// PURPOSE
//   Upstream driver for the 8-digit scanned 7-segment display stage.
//   - Generates the divided scan clock that advances the display's digit selector.
//   - Generates the 8-bit digit-enable vector en[7:0] from a button-selected pattern FSM:
//     all-on, walking digit, progressive fill, blink.
//   - scan_clk and en connect directly to the display stage's clk and en inputs.
// PARAMETERS
//   SCAN_DIV  16          clk cycles per scan_clk half-period (>=1)
//   STEP_DIV  25_000_000  clk cycles per pattern step (>=2)
//   DEB_CYC   250_000     consecutive stable-low clk cycles needed to accept a key press (>=1)
// PORTS
//   clk       in   1  system clock
//   rst_n     in   1  asynchronous reset, active-low
//   key_mode  in   1  raw mode button, active-low, asynchronous to clk
//   scan_clk  out  1  scan clock to display stage, 50% duty, period 2*SCAN_DIV clk
//   en        out  8  digit enables, en[i]=1 lights digit i
//   mode      out  2  current pattern: 0 ALL, 1 WALK, 2 FILL, 3 BLINK
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     scan_clk=0, en=8'hFF, mode=0, all counters=0, debounce disarmed-high.
//   Scan divider
//     - Counter runs 0..SCAN_DIV-1; scan_clk toggles on the cycle the counter wraps.
//     - Free-running, independent of mode, key and pause.
//   Step tick
//     - Counter runs 0..STEP_DIV-1; one-cycle pulse when it wraps.
//     - Counter is cleared on an accepted mode press; next tick follows STEP_DIV cycles later.
//   Debounce (per key)
//     - 2-FF synchronizer, then a stable-low counter.
//     - Press accepted (1-cycle pulse) once DEB_CYC consecutive synced-low samples are seen.
//     - Exactly one pulse per low period; re-armed only after one synced-high sample.
//     - A high sample before DEB_CYC clears the counter.
//     - Latency from raw low to pulse: 2 + DEB_CYC cycles.
//   Mode FSM, advanced by an accepted mode press
//     - ALL -> WALK -> FILL -> BLINK -> ALL.
//     - en is reloaded with the new mode's initial value in the cycle after the press pulse.
//   Patterns (update on step tick only)
//     ALL    en=8'hFF constant.
//     WALK   init 8'h01; rotate left; 8'h80 -> 8'h01.
//     FILL   init 8'h00; en={en[6:0],1'b1}; 8'hFF -> 8'h00.
//     BLINK  init 8'hFF; en=~en each step.
//   Simultaneous events
//     - Press and step tick in the same cycle: press wins (reload, tick discarded).
//   Reset mid-operation
//     - Immediate return to reset values; a press in progress is discarded.
//   Outputs are registered; no combinational path from key_mode to any output.
// CONFIGURATION
//   SEG7_PAUSE_EN defined
//     - Adds input port key_pause (1-bit, raw, active-low), debounced identically.
//     - Each accepted pause press toggles an internal paused flag (reset 0).
//     - While paused, step ticks do not change en; the step counter keeps running.
//     - An accepted mode press clears paused and reloads the pattern.
//     - Pause and mode presses in the same cycle: mode wins, paused=0.
//   SEG7_PAUSE_EN undefined
//     - No key_pause port; paused logic absent; patterns always step.
// TESTING  (SCAN_DIV=2, STEP_DIV=4, DEB_CYC=3)
//   1. Reset release, no keys -> scan_clk toggles every 2 clk; en=FF, mode=0 for 40 cycles.
//   2. key_mode low 10 cycles -> exactly one press pulse 5 cycles after fall; mode 0->1; en=01,
//      then 02,04,.. every 4 cycles; after 80, en=01.
//   3. key_mode glitch low 2 cycles, high 1, low 2 -> no press; mode unchanged.
//   4. Four presses -> mode 1,2,3,0; FILL yields 00,01,03,..,FF,00; BLINK yields FF,00,FF.
//   5. Press coincident with step tick in WALK -> en reloads to 00 (FILL init), no shift;
//      next step 4 cycles later. rst_n low mid-FILL -> en=FF, mode=0, scan_clk=0 same cycle.
//   6. [SEG7_PAUSE_EN] WALK at en=04, pause press -> en holds 04 for 20 cycles; pause press ->
//      08 at next tick. Mode press while paused -> mode=2, en=00, stepping resumes.

Source files
------------

// File: rtl/seg7_en_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_en_ctrl (with helper seg7_key_deb)
// Description : Upstream driver for an 8-digit scanned 7-segment display.
//               Produces the divided scan clock and an 8-bit digit-enable
//               vector. A debounced mode button cycles the enable pattern:
//               all-on, walking digit, progressive fill and blink.
// Ports       : clk       in   1  system clock
//               rst_n     in   1  asynchronous reset, active-low
//               key_mode  in   1  raw mode button, active-low, async to clk
//               key_pause in   1  raw pause button (SEG7_PAUSE_EN builds only)
//               scan_clk  out  1  50% duty scan clock, period 2*SCAN_DIV clk
//               en        out  8  digit enables, en[i]=1 lights digit i
//               mode      out  2  0 ALL, 1 WALK, 2 FILL, 3 BLINK
// Config      : define SEG7_PAUSE_EN to add key_pause and the pause feature.
// Revision    : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// seg7_key_deb: 2-FF synchronizer plus stable-low counter. Emits one
// single-cycle press pulse per low period once DEB_CYC consecutive synced-low
// samples are seen; re-armed by a single synced-high sample.
// ----------------------------------------------------------------------------
module seg7_key_deb #(
  parameter int DEB_CYC = 250_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          armed;
  logic [CW-1:0] low_cnt;

  // Synchronizer resets to the idle (high) level; armed starts low and is
  // set by the first synced-high sample after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      armed   <= 1'b0;
      low_cnt <= '0;
      press   <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2) begin
        armed   <= 1'b1;
        low_cnt <= '0;
      end else if (armed) begin
        if (low_cnt == DEB_LAST) begin
          press   <= 1'b1;
          armed   <= 1'b0;
          low_cnt <= '0;
        end else begin
          low_cnt <= low_cnt + CW'(1);
        end
      end
    end
  end
endmodule

// ----------------------------------------------------------------------------
// seg7_en_ctrl: top level
// ----------------------------------------------------------------------------
module seg7_en_ctrl #(
  parameter int SCAN_DIV = 16,
  parameter int STEP_DIV = 25_000_000,
  parameter int DEB_CYC  = 250_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
`ifdef SEG7_PAUSE_EN
  input  logic       key_pause,
`endif
  output logic       scan_clk,
  output logic [7:0] en,
  output logic [1:0] mode
);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TW = $clog2(STEP_DIV);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] STEP_LAST = TW'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    MODE_ALL   = 2'd0,
    MODE_WALK  = 2'd1,
    MODE_FILL  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_t;

  logic [SW-1:0] scan_cnt;
  logic [TW-1:0] step_cnt;
  logic          step_tick;
  logic          mode_press;
  logic          paused;
  mode_t         mode_q;
  mode_t         mode_nxt;
  logic [7:0]    en_q;
  logic [7:0]    en_nxt;

  // ---------------------------------------------------------------- scan clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_clk <= 1'b0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_clk <= ~scan_clk;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // ------------------------------------------------------------------ step tick
  // An accepted mode press restarts the step period so the new pattern holds
  // its initial value for a full STEP_DIV cycles.
  assign step_tick = (step_cnt == STEP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else if (mode_press || step_tick) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + TW'(1);
    end
  end

  // ------------------------------------------------------------------- buttons
  seg7_key_deb #(.DEB_CYC(DEB_CYC)) u_deb_mode (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_mode),
    .press (mode_press)
  );

`ifdef SEG7_PAUSE_EN
  logic pause_press;

  seg7_key_deb #(.DEB_CYC(DEB_CYC)) u_deb_pause (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_pause),
    .press (pause_press)
  );

  // A mode press always leaves the new pattern running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paused <= 1'b0;
    end else if (mode_press) begin
      paused <= 1'b0;
    end else if (pause_press) begin
      paused <= ~paused;
    end
  end
`else
  assign paused = 1'b0;
`endif

  // ---------------------------------------------------------------- mode FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_ALL;
      en_q   <= 8'hFF;
    end else begin
      mode_q <= mode_nxt;
      en_q   <= en_nxt;
    end
  end

  // A press takes priority over a coincident step tick: the pattern reloads
  // and that tick is dropped.
  always_comb begin
    mode_nxt = mode_q;
    en_nxt   = en_q;
    if (mode_press) begin
      case (mode_q)
        MODE_ALL:   begin mode_nxt = MODE_WALK;  en_nxt = 8'h01; end
        MODE_WALK:  begin mode_nxt = MODE_FILL;  en_nxt = 8'h00; end
        MODE_FILL:  begin mode_nxt = MODE_BLINK; en_nxt = 8'hFF; end
        default:    begin mode_nxt = MODE_ALL;   en_nxt = 8'hFF; end
      endcase
    end else if (step_tick && !paused) begin
      case (mode_q)
        MODE_ALL:   en_nxt = 8'hFF;
        MODE_WALK:  en_nxt = {en_q[6:0], en_q[7]};
        MODE_FILL:  en_nxt = (en_q == 8'hFF) ? 8'h00 : {en_q[6:0], 1'b1};
        default:    en_nxt = ~en_q;
      endcase
    end
  end

  assign en   = en_q;
  assign mode = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_en_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_en_ctrl
// Description : Directed self-checking bench for seg7_en_ctrl with
//               SCAN_DIV=2, STEP_DIV=4, DEB_CYC=3. Inputs change 1 time unit
//               after a rising edge; outputs are sampled at the same point.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_en_ctrl;
  localparam int SCAN_DIV = 2;
  localparam int STEP_DIV = 4;
  localparam int DEB_CYC  = 3;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       key_mode = 1'b1;
`ifdef SEG7_PAUSE_EN
  logic       key_pause = 1'b1;
`endif
  logic       scan_clk;
  logic [7:0] en;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_en_ctrl #(
    .SCAN_DIV (SCAN_DIV),
    .STEP_DIV (STEP_DIV),
    .DEB_CYC  (DEB_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_mode (key_mode),
`ifdef SEG7_PAUSE_EN
    .key_pause(key_pause),
`endif
    .scan_clk (scan_clk),
    .en       (en),
    .mode     (mode)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw low for 6 edges: pulse on the 5th, mode/en reload on the 6th.
  task automatic press_mode();
    key_mode = 1'b0;
    cyc(6);
    key_mode = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    logic       exp_scan;
    logic [7:0] walk_exp [8];
    logic [7:0] fill_exp [9];
    walk_exp = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    fill_exp = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};

    // ---- reset values
    cyc(3);
    check("rst_scan", {7'd0, scan_clk}, 8'h00);
    check("rst_en",   en,               8'hFF);
    check("rst_mode", {6'd0, mode},     8'h00);
    rst_n = 1'b1;

    // ---- 1: idle, scan clock toggles every 2 clk
    cyc(1);
    check("scan_first", {7'd0, scan_clk}, 8'h00);
    exp_scan = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(2);
      exp_scan = ~exp_scan;
      check("scan_tog",  {7'd0, scan_clk}, {7'd0, exp_scan});
      check("idle_en",   en,               8'hFF);
      check("idle_mode", {6'd0, mode},     8'h00);
    end

    // ---- 2: single press, exact latency, WALK stepping
    key_mode = 1'b0;
    cyc(5);
    check("press_early_mode", {6'd0, mode}, 8'h00);
    cyc(1);
    check("press_mode", {6'd0, mode}, 8'h01);
    check("walk_init",  en,           8'h01);
    cyc(3);
    check("walk_hold",  en,           8'h01);
    cyc(1);
    check("walk_step1", en,           8'h02);
    key_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(4);
      check("walk_step", en, walk_exp[i]);
    end
    check("walk_one_pulse", {6'd0, mode}, 8'h01);

    // ---- 3: glitches shorter than DEB_CYC are rejected
    key_mode = 1'b0; cyc(2);
    key_mode = 1'b1; cyc(1);
    key_mode = 1'b0; cyc(2);
    key_mode = 1'b1;
    cyc(10);
    check("glitch_mode", {6'd0, mode}, 8'h01);

    // ---- 4: full mode cycle with FILL and BLINK patterns
    do_reset();
    cyc(4);
    press_mode();
    check("m1_mode", {6'd0, mode}, 8'h01);
    check("m1_en",   en,           8'h01);
    cyc(4);
    press_mode();
    check("m2_mode", {6'd0, mode}, 8'h02);
    check("m2_en",   en,           8'h00);
    for (int i = 0; i < 9; i++) begin
      cyc(4);
      check("fill_step", en, fill_exp[i]);
    end
    press_mode();
    check("m3_mode", {6'd0, mode}, 8'h03);
    check("m3_en",   en,           8'hFF);
    cyc(4);
    check("blink_1", en, 8'h00);
    cyc(4);
    check("blink_2", en, 8'hFF);
    press_mode();
    check("m0_mode", {6'd0, mode}, 8'h00);
    check("m0_en",   en,           8'hFF);
    cyc(4);
    check("all_hold", en, 8'hFF);

    // ---- 5: press coincident with step tick in WALK, then async reset
    press_mode();
    check("w_mode", {6'd0, mode}, 8'h01);
    cyc(2);
    press_mode();          // accepting edge is also a step-tick edge
    check("coin_mode", {6'd0, mode}, 8'h02);
    check("coin_en",   en,           8'h00);
    cyc(3);
    check("coin_hold", en, 8'h00);
    cyc(1);
    check("coin_step", en, 8'h01);
    cyc(2);
    rst_n = 1'b0;
    #1;
    check("arst_en",   en,               8'hFF);
    check("arst_mode", {6'd0, mode},     8'h00);
    check("arst_scan", {7'd0, scan_clk}, 8'h00);
    cyc(1);
    rst_n = 1'b1;

`ifdef SEG7_PAUSE_EN
    // ---- 6: pause feature
    do_reset();
    cyc(4);
    press_mode();
    check("p_walk", en, 8'h01);
    cyc(2);
    key_pause = 1'b0;
    cyc(6);                // pause lands on the tick edge that shows 04
    key_pause = 1'b1;
    check("p_at04", en, 8'h04);
    for (int i = 0; i < 5; i++) begin
      cyc(4);
      check("p_hold", en, 8'h04);
    end
    key_pause = 1'b0;
    cyc(6);
    key_pause = 1'b1;
    check("unp_hold", en, 8'h04);
    cyc(1);
    check("unp_hold2", en, 8'h04);
    cyc(1);
    check("unp_step", en, 8'h08);
    key_pause = 1'b0;
    cyc(6);
    key_pause = 1'b1;
    check("p2_en", en, 8'h10);
    cyc(4);
    check("p2_hold", en, 8'h10);
    press_mode();
    check("p_mode_mode", {6'd0, mode}, 8'h02);
    check("p_mode_en",   en,           8'h00);
    cyc(4);
    check("p_resume", en, 8'h01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
